trajectory_point_generator: RTL and testbench

Computes the pixel trajectory of one launched missile and streams it, one point at a time, as 19-bit linear VGA frame addresses (y*640 + x) with a one-cycle write strobe. It sits directly upstream of the trajectory buffer writer: its `trajectory_memloc` / `trajectory_memloc_enable` outputs drive that writer's identically named inputs. Motion is integrated in signed fixed point with constant downward gravity. The stream terminates when the shell leaves the screen or hits a point/step limit.

---
 rtl/trajectory_point_generator.sv | 132 +++++++++++++
 tb/tb_trajectory_point_generator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trajectory_point_generator.sv
// Integrates one missile shell in Q.FRAC fixed point and streams on-screen points as VGA addresses (y*640 + x).
// Latency: first strobe 2 cycles after an accepted start; 3 cycles per on-screen point, 2 per above-screen step.
// No backpressure: strobes are fire-and-forget; start is ignored unless IDLE.
module trajectory_point_generator #(
    parameter int FRAC       = 4,
    parameter int GRAVITY    = 3,
    parameter int MAX_POINTS = 400,
    parameter int MAX_STEPS  = 1023
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [15:0] vx,
    input  logic [15:0] vy,
    output logic [18:0] trajectory_memloc,
    output logic        trajectory_memloc_enable,
    output logic        busy,
    output logic        done,
    output logic [8:0]  point_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EMIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [15:0] px, py, vxr, vyr;
    logic [9:0]         step_cnt;

    logic signed [15:0] xi, yi;
    logic               off_screen;
    logic               limit_hit;
    logic [18:0]        yi_ext;
    logic [18:0]        memloc_calc;
    logic               do_load;
    logic               do_capture;

    assign xi = px >>> FRAC;
    assign yi = py >>> FRAC;

    assign off_screen = (xi < 16'sd0) || (xi > 16'sd639) || (yi > 16'sd479);
    assign limit_hit  = (point_count == 9'(MAX_POINTS)) || (step_cnt == 10'(MAX_STEPS));

    // Only consumed when on screen, so yi fits in 9 bits and xi in 10.
    assign yi_ext      = 19'(yi[8:0]);
    assign memloc_calc = (yi_ext << 9) + (yi_ext << 7) + 19'(xi[9:0]);

    always_comb begin
        state_nxt  = state;
        do_load    = 1'b0;
        do_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    do_load   = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (off_screen || limit_hit) begin
                    state_nxt = S_DONE;
                end else if (yi[15]) begin
                    state_nxt = S_ADVANCE;
                end else begin
                    do_capture = 1'b1;
                    state_nxt  = S_EMIT;
                end
            end
            S_EMIT:    state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = S_CHECK;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so the strobe is a clean flop output.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state                    <= S_IDLE;
            trajectory_memloc_enable <= 1'b0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
        end else begin
            state                    <= state_nxt;
            trajectory_memloc_enable <= (state_nxt == S_EMIT);
            busy                     <= (state_nxt == S_CHECK) || (state_nxt == S_EMIT) ||
                                        (state_nxt == S_ADVANCE);
            done                     <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            px                <= '0;
            py                <= '0;
            vxr               <= '0;
            vyr               <= '0;
            step_cnt          <= '0;
            point_count       <= '0;
            trajectory_memloc <= '0;
        end else begin
            if (do_load) begin
                px          <= 16'(x0) << FRAC;
                py          <= 16'(y0) << FRAC;
                vxr         <= vx;
                vyr         <= vy;
                step_cnt    <= '0;
                point_count <= '0;
            end
            if (do_capture) begin
                trajectory_memloc <= memloc_calc;
            end
            if (state == S_EMIT) begin
                point_count <= point_count + 9'd1;
            end
            if (state == S_ADVANCE) begin
                px       <= px + vxr;
                py       <= py + vyr;
                vyr      <= vyr + 16'(GRAVITY);
                step_cnt <= step_cnt + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_trajectory_point_generator.sv
// Directed bench: two instances (gravity 0 and 16) driven from a vector table, a point-by-point reference model,
// and hand-written sequences for start spamming and mid-run reset.
module tb_trajectory_point_generator;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start0 = 1'b0;
    logic        start16 = 1'b0;
    logic [9:0]  x0 = '0;
    logic [8:0]  y0 = '0;
    logic [15:0] vx = '0;
    logic [15:0] vy = '0;

    logic [18:0] loc0, loc16;
    logic        en0, en16, busy0, busy16, done0, done16;
    logic [8:0]  pc0, pc16;

    trajectory_point_generator #(.GRAVITY(0)) u0 (
        .clock(clock), .resetn(resetn), .start(start0),
        .x0(x0), .y0(y0), .vx(vx), .vy(vy),
        .trajectory_memloc(loc0), .trajectory_memloc_enable(en0),
        .busy(busy0), .done(done0), .point_count(pc0)
    );

    trajectory_point_generator #(.GRAVITY(16)) u16 (
        .clock(clock), .resetn(resetn), .start(start16),
        .x0(x0), .y0(y0), .vx(vx), .vy(vy),
        .trajectory_memloc(loc16), .trajectory_memloc_enable(en16),
        .busy(busy16), .done(done16), .point_count(pc16)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    bit          gsel = 1'b0;
    logic [18:0] s_loc;
    logic        s_en, s_busy, s_done;
    logic [8:0]  s_pc;

    always_comb begin
        s_loc  = gsel ? loc16  : loc0;
        s_en   = gsel ? en16   : en0;
        s_busy = gsel ? busy16 : busy0;
        s_done = gsel ? done16 : done0;
        s_pc   = gsel ? pc16   : pc0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected addresses, strobe cycles and done cycle (cycle 1 = first CHECK).
    int exp_loc[$];
    int exp_cyc[$];
    int exp_done;

    function automatic int fdiv16(input int a);
        if (a >= 0) return a / 16;
        return -((-a + 15) / 16);
    endfunction

    task automatic model(input bit g, input int ax0, input int ay0, input int avx, input int avy);
        int px, py, mvy, xi, yi, pc, sc, cyc;
        exp_loc.delete();
        exp_cyc.delete();
        px = ax0 * 16; py = ay0 * 16; mvy = avy;
        pc = 0; sc = 0; cyc = 1;
        forever begin
            xi = fdiv16(px);
            yi = fdiv16(py);
            if (xi < 0 || xi > 639 || yi > 479) break;
            if (pc == 400 || sc == 1023) break;
            if (yi >= 0) begin
                exp_loc.push_back(yi * 640 + xi);
                exp_cyc.push_back(cyc + 1);
                pc++;
                cyc += 3;
            end else begin
                cyc += 2;
            end
            px += avx;
            py += mvy;
            mvy += g ? 16 : 0;
            sc++;
        end
        exp_done = cyc + 1;
    endtask

    // Leaves start asserted when hold is set; returns just after the accepting edge.
    task automatic launch(input bit g, input int ax0, input int ay0, input int avx, input int avy, input bit hold);
        @(posedge clock);
        #1;
        gsel = g;
        x0 = 10'(ax0); y0 = 9'(ay0); vx = 16'(avx); vy = 16'(avy);
        if (g) start16 = 1'b1; else start0 = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) begin
            start0 = 1'b0;
            start16 = 1'b0;
        end
    endtask

    task automatic capture(input bit g, input int ax0, input int ay0, input int avx, input int avy,
                           output int npts, output int first, output int last);
        bit prev_en = 1'b0;
        bit got_done = 1'b0;
        int idx = 0;
        model(g, ax0, ay0, avx, avy);
        first = -1; last = -1;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clock);
            if (c == 1) chk("busy_after_start", s_busy, 1);
            if (s_en) begin
                if (prev_en) chk("strobe_back_to_back", 1, 0);
                if (idx < exp_loc.size()) begin
                    chk("strobe_memloc", s_loc, exp_loc[idx]);
                    chk("strobe_cycle", c, exp_cyc[idx]);
                end else begin
                    chk("extra_strobe", idx, exp_loc.size());
                end
                if (idx == 0) first = int'(s_loc);
                last = int'(s_loc);
                idx++;
            end
            if (s_done) begin
                chk("done_cycle", c, exp_done);
                chk("busy_low_at_done", s_busy, 0);
                chk("point_count_at_done", s_pc, exp_loc.size());
                got_done = 1'b1;
                break;
            end
            prev_en = s_en;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        npts = idx;
    endtask

    typedef struct {
        bit g;
        int x0, y0, vx, vy;
        int pts, first, last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int npts, first, last, seen;
        bit bad;

        // Hand-computed: {gravity16, x0, y0, vx, vy, points, first memloc, last memloc}
        vecs[0] = '{0, 0,   100, 16,  0,   400, 64000,  64399};   // point cap
        vecs[1] = '{0, 635, 0,   16,  0,   5,   635,    639};     // right edge exit
        vecs[2] = '{0, 2,   0,   -16, 0,   3,   2,      0};       // left edge exit
        vecs[3] = '{0, 5,   0,   0,   -16, 1,   5,      5};       // climbs forever, step cap
        vecs[4] = '{1, 10,  2,   0,   -48, 29,  1290,   295050};  // arc above the screen
        vecs[5] = '{1, 0,   470, 16,  0,   5,   300800, 304644};  // parabola landing at y=480
        vecs[6] = '{1, 639, 479, 0,   0,   2,   307199, 307199};  // bottom-right pixel

        #12;
        chk("reset_memloc", loc0, 0);
        chk("reset_enable", en0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_point_count", pc0, 0);
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i].g, vecs[i].x0, vecs[i].y0, vecs[i].vx, vecs[i].vy, 1'b0);
            capture(vecs[i].g, vecs[i].x0, vecs[i].y0, vecs[i].vx, vecs[i].vy, npts, first, last);
            chk($sformatf("vec%0d_points", i), npts, vecs[i].pts);
            chk($sformatf("vec%0d_first", i), first, vecs[i].first);
            chk($sformatf("vec%0d_last", i), last, vecs[i].last);
            @(negedge clock);
            chk($sformatf("vec%0d_done_single", i), s_done, 0);
            chk($sformatf("vec%0d_count_hold", i), s_pc, vecs[i].pts);
        end

        // start held high for the whole run, then re-accepted one cycle after done
        launch(0, 635, 0, 16, 0, 1'b1);
        capture(0, 635, 0, 16, 0, npts, first, last);
        chk("spam_points", npts, 5);
        @(negedge clock);
        chk("spam_idle_after_done", busy0, 0);
        @(posedge clock);
        #1;
        start0 = 1'b0;
        capture(0, 635, 0, 16, 0, npts, first, last);
        chk("restart_points", npts, 5);
        chk("restart_first", first, 635);

        // reset between strobes
        launch(0, 0, 100, 16, 0, 1'b0);
        seen = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge clock);
            if (en0) seen++;
        end
        chk("pre_reset_strobes", seen, 3);
        @(negedge clock);
        chk("pre_reset_count", pc0, 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_memloc", loc0, 0);
        chk("async_enable", en0, 0);
        chk("async_busy", busy0, 0);
        chk("async_point_count", pc0, 0);
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done0 || busy0 || en0) bad = 1'b1;
        end
        chk("no_done_in_reset", bad, 0);
        resetn = 1'b1;
        launch(0, 635, 0, 16, 0, 1'b0);
        capture(0, 635, 0, 16, 0, npts, first, last);
        chk("post_reset_points", npts, 5);
        chk("post_reset_first", first, 635);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
